// File: rtl/per_bus_master_pkg.sv
// per_bus_master_pkg: shared bus field layout, idle address, command record and FSM states
// for the peripheral-bus master.
package per_bus_master_pkg;
    localparam int BUS_WE_BIT   = 22;
    localparam int BUS_ADDR_MSB = 21;
    localparam int BUS_ADDR_LSB = 16;
    localparam int BUS_RD_MSB   = 15;
    localparam int BUS_RD_LSB   = 8;
    localparam int BUS_WR_MSB   = 7;
    localparam int BUS_WR_LSB   = 0;
    localparam logic [5:0] BUS_IDLE_ADDR = 6'd63;
    localparam int CMD_W = 15;
    typedef struct packed {
        logic       we;
        logic [5:0] addr;
        logic [7:0] wdata;
    } cmd_t;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RWAIT,
        ST_RESP
    } state_e;
endpackage

// File: rtl/per_cmd_fifo.sv
// per_cmd_fifo: synchronous first-word-fall-through command FIFO with full/empty flags.
module per_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;
    assign full    = count_q == (AW+1)'(DEPTH);
    assign empty   = count_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/per_bus_master.sv
// per_bus_master: queues CPU commands and replays them as timed setup/strobe-or-wait/hold
// cycles on the shared peripheral bus, returning read data with a one-cycle pulse.
module per_bus_master #(
    parameter int         FIFO_DEPTH    = 4,
    parameter int         STROBE_CYCLES = 2,
    parameter int         READ_WAIT     = 3,
    parameter logic [5:0] IDLE_ADDR     = per_bus_master_pkg::BUS_IDLE_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic       cmdWe,
    input  logic [5:0] cmdAddr,
    input  logic [7:0] cmdWdata,
    output logic       rspValid,
    output logic [7:0] rspData,
    output logic       busy,
    output logic       busWe,
    output logic [5:0] busAddr,
    output logic [7:0] busWdata,
    input  logic [7:0] busRdata
);
    import per_bus_master_pkg::*;
    localparam int CNT_MAX = STROBE_CYCLES > READ_WAIT ? STROBE_CYCLES : READ_WAIT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            bus_we_q, bus_we_d;
    logic [5:0]      bus_addr_q, bus_addr_d;
    logic [7:0]      bus_wdata_q, bus_wdata_d;
    logic [7:0]      rsp_data_q, rsp_data_d;
    logic            cur_we_q, cur_we_d;
    logic            pop, full, empty;
    logic [CMD_W-1:0] fifo_dout;
    cmd_t            head;
    per_cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(CMD_W)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (cmdValid && !full),
        .pop  (pop),
        .din  ({cmdWe, cmdAddr, cmdWdata}),
        .dout (fifo_dout),
        .full (full),
        .empty(empty)
    );
    assign head     = cmd_t'(fifo_dout);
    assign cmdReady = !full;
    assign busy     = !empty || state_q != ST_IDLE;
    assign rspValid = state_q == ST_RESP;
    assign rspData  = rsp_data_q;
    assign busWe    = bus_we_q;
    assign busAddr  = bus_addr_q;
    assign busWdata = bus_wdata_q;
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rsp_data_d  = rsp_data_q;
        cur_we_d    = cur_we_q;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus_we_d   = 1'b0;
                bus_addr_d = IDLE_ADDR;
                if (!empty) begin
                    pop      = 1'b1;
                    cur_we_d = head.we;
                    // The idle address is never put on the bus: reads of it answer 0, writes vanish
                    if (head.addr != IDLE_ADDR) begin
                        bus_addr_d  = head.addr;
                        bus_wdata_d = head.wdata;
                        state_d     = ST_SETUP;
                    end else if (!head.we) begin
                        rsp_data_d = 8'h00;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_SETUP: begin
                bus_we_d = cur_we_q;
                cnt_d    = cur_we_q ? CW'(STROBE_CYCLES - 1) : CW'(READ_WAIT - 1);
                state_d  = cur_we_q ? ST_STROBE : ST_RWAIT;
            end
            ST_STROBE: begin
                bus_we_d = cnt_q != '0;
                cnt_d    = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                state_d  = cnt_q == '0 ? ST_HOLD : ST_STROBE;
            end
            ST_HOLD: begin
                bus_addr_d = IDLE_ADDR;
                state_d    = ST_IDLE;
            end
            ST_RWAIT: begin
                rsp_data_d = cnt_q == '0 ? busRdata : rsp_data_q;
                cnt_d      = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
                state_d    = cnt_q == '0 ? ST_RESP : ST_RWAIT;
            end
            ST_RESP: begin
                bus_addr_d = IDLE_ADDR;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= IDLE_ADDR;
            bus_wdata_q <= 8'h00;
            rsp_data_q  <= 8'h00;
            cur_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_data_q  <= rsp_data_d;
            cur_we_q    <= cur_we_d;
        end
    end
endmodule

// File: tb/tb_per_bus_master.sv
// tb_per_bus_master: random and directed commands checked against an in-order transaction
// model with exact per-cycle bus timing derived from the phase lengths.
module tb_per_bus_master;
    localparam int         STROBE = 2;
    localparam int         RW     = 3;
    localparam logic [5:0] IDLE   = 6'd63;
    typedef struct {
        int         kind;
        logic [5:0] addr;
        logic [7:0] data;
    } ev_t;
    logic       clk = 1'b0, rst = 1'b1;
    logic       cmdValid = 1'b0, cmdWe = 1'b0;
    logic [5:0] cmdAddr = '0;
    logic [7:0] cmdWdata = '0;
    logic       cmdReady, rspValid, busy, busWe;
    logic [7:0] rspData, busWdata, busRdata;
    logic [5:0] busAddr;
    logic [7:0] periph [64];
    int         checks = 0, errors = 0;
    ev_t        exp_q[$];
    ev_t        cur;
    bit         active = 0, mon_en = 0;
    int         age = 0;
    assign busRdata = periph[busAddr];
    always #5 clk = ~clk;
    per_bus_master dut (
        .clk(clk), .rst(rst),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWe(cmdWe), .cmdAddr(cmdAddr), .cmdWdata(cmdWdata),
        .rspValid(rspValid), .rspData(rspData), .busy(busy),
        .busWe(busWe), .busAddr(busAddr), .busWdata(busWdata), .busRdata(busRdata)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    // kind 0 = bus write, 1 = bus read (data = expected response), 2 = response without bus cycle
    task automatic expect_cmd(input logic we, input logic [5:0] a, input logic [7:0] d);
        ev_t e;
        e.addr = a;
        e.kind = a == IDLE ? 2 : (we ? 0 : 1);
        e.data = a == IDLE ? 8'h00 : (we ? d : periph[a]);
        if (!(we && a == IDLE)) exp_q.push_back(e);
    endtask
    task automatic monitor();
        ev_t e;
        if (active) begin
            age++;
            if (age == (cur.kind == 0 ? STROBE + 2 : RW + 2)) begin
                chk("bus_idle_return", busAddr, IDLE);
                chk("we_after_cycle", busWe, 0);
                chk("rsp_after_cycle", rspValid, 0);
                active = 0;
            end else begin
                chk("addr_hold", busAddr, cur.addr);
                if (cur.kind == 0) chk("wdata_hold", busWdata, cur.data);
                chk("we_window", busWe, cur.kind == 0 && age <= STROBE);
                chk("rsp_timing", rspValid, cur.kind == 1 && age == RW + 1);
                if (cur.kind == 1 && age == RW + 1) chk("rsp_data", rspData, cur.data);
            end
        end else if (busAddr != IDLE) begin
            chk("bus_cycle_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) cur = exp_q.pop_front();
            else begin cur.kind = 1; cur.addr = busAddr; cur.data = 8'h00; end
            chk("bus_not_rsp_only", cur.kind != 2, 1);
            chk("bus_addr", busAddr, cur.addr);
            if (cur.kind == 0) chk("bus_wdata", busWdata, cur.data);
            chk("we_setup", busWe, 0);
            chk("rsp_setup", rspValid, 0);
            active = 1;
            age = 0;
        end else begin
            chk("we_idle", busWe, 0);
            if (rspValid) begin
                chk("rsp_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("rsp_only_kind", e.kind, 2);
                    chk("rsp_idle_data", rspData, e.data);
                end
            end
        end
    endtask
    task automatic tick();
        @(negedge clk);
        if (mon_en) monitor();
    endtask
    task automatic send(input logic we, input logic [5:0] a, input logic [7:0] d);
        int n = 0;
        cmdValid = 1'b1; cmdWe = we; cmdAddr = a; cmdWdata = d;
        while (!cmdReady && n < 200) begin tick(); n++; end
        chk("accept_timeout", n < 200, 1);
        if (n < 200) expect_cmd(we, a, d);
        tick();
        cmdValid = 1'b0;
    endtask
    task automatic drain();
        int n = 0;
        while ((exp_q.size() > 0 || active || busy) && n < 2000) begin tick(); n++; end
        chk("drain", n < 2000, 1);
    endtask
    initial begin
        for (int i = 0; i < 64; i++) periph[i] = 8'($urandom);
        periph[14] = 8'hC3;
        repeat (3) tick();
        chk("rst_busWe", busWe, 0);
        chk("rst_busAddr", busAddr, IDLE);
        chk("rst_busWdata", busWdata, 0);
        chk("rst_rspValid", rspValid, 0);
        chk("rst_rspData", rspData, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmdReady", cmdReady, 1);
        rst = 1'b0;
        mon_en = 1;
        tick();
        send(1'b1, 6'd13, 8'h5A);
        chk("lat_e0_addr", busAddr, IDLE);
        chk("lat_e0_busy", busy, 1);
        tick();
        chk("lat_e1_addr", busAddr, 6'd13);
        chk("lat_e1_wdata", busWdata, 8'h5A);
        drain();
        send(1'b0, 6'd14, 8'h00);
        drain();
        chk("rsp_hold_c3", rspData, 8'hC3);
        send(1'b1, 6'd12, 8'h00);
        for (int i = 0; i < 4; i++) send(1'b1, 6'(13 + i), 8'(i + 1));
        chk("full_ready_low", cmdReady, 0);
        send(1'b1, 6'd17, 8'h05);
        drain();
        send(1'b1, 6'd15, 8'h11);
        send(1'b0, 6'd16, 8'h00);
        send(1'b1, 6'd17, 8'h22);
        drain();
        send(1'b0, IDLE, 8'h00);
        send(1'b1, IDLE, 8'h77);
        drain();
        chk("rsp_idle_zero", rspData, 8'h00);
        for (int i = 0; i < 40; i++) begin
            logic [5:0] a;
            repeat ($urandom_range(0, 3)) tick();
            a = ($urandom_range(0, 5) == 0) ? IDLE : 6'($urandom_range(0, 62));
            send(1'($urandom), a, 8'($urandom));
        end
        drain();
        send(1'b1, 6'd20, 8'hA1);
        send(1'b1, 6'd21, 8'hA2);
        send(1'b0, 6'd22, 8'h00);
        begin
            int n = 0;
            while (!busWe && n < 50) begin tick(); n++; end
            chk("strobe_seen", busWe, 1);
        end
        rst = 1'b1;
        mon_en = 0;
        tick();
        exp_q.delete();
        active = 0;
        chk("mid_rst_busWe", busWe, 0);
        chk("mid_rst_busAddr", busAddr, IDLE);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmdReady", cmdReady, 1);
        chk("mid_rst_rspValid", rspValid, 0);
        rst = 1'b0;
        mon_en = 1;
        repeat (30) tick();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_queue", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/per_bus_master.md
Name: per_bus_master

Overview:
- Peripheral-bus master that sits directly upstream of the peripherals on the 23-bit shared peripheral bus (the VGA peripheral among them).
- Bus field layout: bit 22 = we, 21:16 = address, 15:8 = data returned by the peripheral, 7:0 = data written to the peripheral.
- Accepts CPU read/write commands through a valid/ready handshake into a small in-order command FIFO.
- Sequences each command as a timed bus cycle (setup, strobe or wait, hold) so slower-clocked peripherals see stable address and data, and returns read data with a one-cycle response pulse.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries; power of two, at least 2.
- STROBE_CYCLES, 2, cycles we is held high per write; at least 1.
- READ_WAIT, 3, cycles between address setup and read-data sampling; at least 1.
- IDLE_ADDR, 6'd63, address driven when the bus is idle; no peripheral decodes it.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- cmdValid  in  1  command offered.
- cmdReady  out  1  FIFO can accept; equals !full.
- cmdWe  in  1  1 = write, 0 = read.
- cmdAddr  in  6  peripheral register address.
- cmdWdata  in  8  write data.
- rspValid  out  1  one-cycle pulse; read data valid.
- rspData  out  8  read data, held until the next response.
- busy  out  1  FIFO non-empty or FSM not in IDLE.
- busWe  out  1  drives bus bit 22.
- busAddr  out  6  drives bus bits 21:16.
- busWdata  out  8  drives bus bits 7:0.
- busRdata  in  8  bus bits 15:8.

Behaviour:
- Interface rule: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - busWe = 0, busAddr = IDLE_ADDR, busWdata = 0.
  - rspValid = 0, rspData = 0, busy = 0.
  - FIFO empty, so cmdReady = 1; FSM in IDLE.
- Reset mid-operation: at the reset edge the bus returns to idle immediately, the FIFO is flushed, and no response is issued for the aborted or queued commands.
- Accept and FIFO:
  - A command is accepted on any edge where cmdValid && cmdReady.
  - cmdReady = !full, registered-state only; it does not depend combinationally on a same-cycle pop.
  - Push and pop in the same cycle are legal when not full; the count is unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, SETUP, STROBE, HOLD, RWAIT, RESP. All bus outputs are registered.
- IDLE:
  - If the FIFO is non-empty: pop, latch the entry, drive busAddr and busWdata, busWe = 0, go to SETUP.
  - Otherwise busAddr = IDLE_ADDR and busWe = 0.
  - Special case: a read with cmdAddr == IDLE_ADDR runs no bus cycle. It pops and goes straight to RESP with rspData = 8'h00.
  - A write with cmdAddr == IDLE_ADDR is popped and discarded.
- SETUP (1 cycle): go to STROBE if write, RWAIT if read.
- STROBE: busWe = 1 for exactly STROBE_CYCLES cycles, using a counter; then go to HOLD.
- HOLD (1 cycle): busWe = 0, address and data still held; then IDLE.
- RWAIT: lasts READ_WAIT cycles. On its final edge, capture busRdata into rspData and go to RESP.
- RESP (1 cycle): rspValid = 1; then IDLE.
- Timing with defaults, cycle counts between IDLE pops:
  - Write: SETUP 1 + STROBE 2 + HOLD 1 = 4 cycles; busWe high for exactly 2 cycles.
  - Read: SETUP 1 + RWAIT 3 + RESP 1 = 5 cycles.
- Command-to-bus latency: a command accepted at edge E0 into an empty FIFO drives busAddr from edge E1.
- Ordering: commands complete strictly in accept order. Responses are produced for reads only.
- busWdata and busAddr never change while busWe = 1.
- busy: combinational OR of FIFO non-empty and state != IDLE.

Decomposition:
- Shared package/header holds:
  - Bus field constants: BUS_WE_BIT = 22, BUS_ADDR_MSB/LSB = 21/16, BUS_RD_MSB/LSB = 15/8, BUS_WR_MSB/LSB = 7/0.
  - IDLE_ADDR.
  - FSM state encodings.
- One sub-module, per_cmd_fifo: synchronous FIFO, 15 bits wide ({we, addr, wdata}), depth FIFO_DEPTH, with full/empty outputs.
- The top-level bus wrapper assembles the inout bus from busWe, busAddr, busWdata and busRdata; this block contains no tristates.

Test Plan:
1. Reset, then write 0x5A to address 13 → busAddr = 13 and busWdata = 0x5A from E1. busWe high exactly 2 cycles. busAddr returns to 63 after HOLD. No rspValid.
2. Read address 14 with busRdata = 0xC3 stable → rspValid pulses once, 5 cycles after the pop, with rspData = 0xC3. busWe stays 0 throughout.
3. Back-to-back: 5 writes offered on consecutive cycles while the FSM is busy → cmdReady drops after the 4th is queued. The 5th is accepted once a pop frees space. All 5 appear on the bus in order: addresses 13..17, data 0x01..0x05.
4. Mixed sequence: write 0x11 to 15, read 16, write 0x22 to 17 → bus order is write, read, write. Exactly one rspValid pulse, and it arrives before the second write's busWe rises.
5. Read of address 63 → no bus activity (busAddr stays 63). rspValid pulses with rspData = 0x00. A write to 63 produces no busWe pulse.
6. Assert rst during the STROBE of a write with 2 commands queued → busWe = 0 and busAddr = 63 the cycle after the reset edge. busy = 0, cmdReady = 1. No bus cycles or responses follow.
